jtframe_prog_pack: RTL and testbench
====================================

JTFRAME_PROG_PACK -- requirements
Module: jtframe_prog_pack

Interface
REQ-001 Parameter SDRAMW, 23: width of prog_addr in 16-bit words.
REQ-002 Parameter HEADER, 0: count of leading download bytes that are discarded.
REQ-003 Parameter BA1_START, 25'h10_0000: first byte address, after the header, that maps to bank 1.
REQ-004 Parameter BA2_START, 25'h18_0000: first byte address that maps to bank 2.
REQ-005 Parameter BA3_START, 25'h1C_0000: first byte address that maps to bank 3; the parameters SHALL satisfy BA1_START <= BA2_START <= BA3_START.
REQ-006 clk  in  1  single clock, the SDRAM/ROM clock domain.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 downloading  in  1  high while the SPI loader streams ROM data.
REQ-009 ioctl_addr  in  25  byte address of ioctl_data.
REQ-010 ioctl_data  in  8  download byte.
REQ-011 ioctl_wr  in  1  one-cycle byte strobe.
REQ-012 prog_addr  out  SDRAMW  word address within the selected bank.
REQ-013 prog_data  out  16  write data, equal to {byte,byte}.
REQ-014 prog_mask  out  2  active-low byte enable: 2'b10 for an even byte, 2'b01 for an odd byte.
REQ-015 prog_ba  out  2  SDRAM bank.
REQ-016 prog_we  out  1  write request, held until accepted.
REQ-017 prog_rdy  in  1  one-cycle pulse that completes the current write.
REQ-018 dwnld_busy  out  1  high while download or writes are pending.
REQ-019 overflow  out  1  sticky flag set when a byte is lost.

Function
REQ-020 Address mapping: r = ioctl_addr - HEADER; bank = highest k with r >= BAk_START (k = 3, 2, 1), else bank 0 with start 0; prog_addr = (r - start)[SDRAMW:1].
REQ-021 A strobe with ioctl_addr < HEADER, or with downloading low, SHALL be ignored.
REQ-022 Accepted bytes SHALL enter a 4-entry FIFO of {prog_ba, prog_addr, byte, odd} computed at the strobe cycle.
REQ-023 FSM IDLE: when the FIFO is non-empty, pop the head, drive the prog_* fields, assert prog_we, and go to WRITE.
REQ-024 FSM WRITE: hold prog_we and all prog_* outputs stable; on prog_rdy, deassert prog_we the next cycle and return to IDLE.
REQ-025 Latency: a strobe at cycle n into an empty FIFO in IDLE SHALL give prog_we high at cycle n+2.
REQ-026 A pop and a push in the same cycle SHALL keep the FIFO occupancy unchanged.
REQ-027 A strobe while the FIFO is full and no pop occurs SHALL drop the byte and set overflow until reset.
REQ-028 prog_rdy while in IDLE SHALL be ignored.
REQ-029 dwnld_busy = downloading | FIFO non-empty | (state == WRITE), registered, so it falls one cycle after the last write completes.
REQ-030 Pointer wrap-around at 4 entries SHALL preserve FIFO ordering.

Reset
REQ-031 While rst is asserted, prog_we = 0, prog_addr = 0, prog_data = 0, prog_mask = 2'b11, prog_ba = 0, dwnld_busy = 0, overflow = 0, FIFO empty, and FSM in IDLE.
REQ-032 A reset during WRITE SHALL abandon the pending write; no retry after reset.

Structure
REQ-033 The FSM state enum and the FIFO depth constant (4) SHALL live in the shared package jtframe_pkg.
REQ-034 One sub-module, jtframe_prog_fifo (synchronous FIFO, width and depth as parameters), SHALL hold the buffer; mapping and FSM stay in the top.

Verification
REQ-035 HEADER = 0, byte 8'hA5 at address 3, prog_rdy two cycles after prog_we -> prog_ba = 0, prog_addr = 1, prog_data = 16'hA5A5, prog_mask = 2'b01, prog_we high for exactly 3 cycles.
REQ-036 Address 25'h10_0004 -> prog_ba = 1, prog_addr = 2, prog_mask = 2'b10; address 25'h1C_0001 -> prog_ba = 3, prog_addr = 0.
REQ-037 HEADER = 16, strobes at addresses 0..17 -> only addresses 16 and 17 are written, at prog_addr 0 with masks 10 then 01.
REQ-038 prog_rdy held low, 5 back-to-back strobes -> 1 write in flight plus 4 queued, overflow stays 0; a 6th strobe -> overflow = 1; releasing prog_rdy -> the first 5 bytes are written in order.
REQ-039 rst asserted mid-WRITE with 2 bytes queued -> prog_we = 0 immediately; after release, no writes occur and dwnld_busy follows downloading.

Source files
------------

// File: rtl/jtframe_pkg.sv
// Shared definitions for the ROM download packer: write FSM states and buffer depth.
package jtframe_pkg;

  localparam int PROG_FIFO_DEPTH = 32'sd4;

  typedef enum logic [0:0] {
    PROG_IDLE  = 1'b0,
    PROG_WRITE = 1'b1
  } prog_state_t;

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Small synchronous FIFO with occupancy counter; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module jtframe_prog_fifo #(
  parameter int W     = 32'sd8,
  parameter int DEPTH = 32'sd4
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = (DEPTH > 32'sd1) ? $clog2(DEPTH) : 32'sd1;
  localparam int CW = $clog2(DEPTH + 32'sd1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          push_ok_s, pop_ok_s;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 32'sd1)) begin
      return {AW{1'b0}};
    end else begin
      return ptr + 1'b1;
    end
  endfunction

  assign empty     = (cnt_r == {CW{1'b0}});
  assign full      = (cnt_r == CW'(DEPTH));
  assign push_ok_s = push & (~full | pop);
  assign pop_ok_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop_ok_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/jtframe_prog_pack.sv
// Packs downloaded ROM bytes into SDRAM word writes: bank decode at the strobe,
// a short FIFO to absorb bursts, and a request/acknowledge write FSM.
module jtframe_prog_pack
  import jtframe_pkg::*;
#(
  parameter int          SDRAMW    = 32'sd23,
  parameter int          HEADER    = 32'sd0,
  parameter logic [24:0] BA1_START = 25'h10_0000,
  parameter logic [24:0] BA2_START = 25'h18_0000,
  parameter logic [24:0] BA3_START = 25'h1C_0000
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  localparam int EW = SDRAMW + 32'sd11;

  logic [25:0]       diff_s;
  logic [24:0]       rel_s, start_s;
  logic [1:0]        bank_s;
  logic [SDRAMW-1:0] waddr_s;
  logic              accept_s, pop_s, empty_s, full_s;
  logic [EW-1:0]     push_data_s, head_s;
  logic [1:0]        head_ba_s;
  logic [SDRAMW-1:0] head_addr_s;
  logic [7:0]        head_byte_s;
  logic              head_odd_s;
  prog_state_t       state_r, state_nx;
  logic [SDRAMW-1:0] addr_r;
  logic [15:0]       data_r;
  logic [1:0]        mask_r, ba_r;
  logic              we_r, busy_r, ovf_r;

  // Header removal and bank decode; the borrow bit flags addresses inside the header
  always_comb begin
    diff_s = {1'b0, ioctl_addr} - {1'b0, 25'(HEADER)};
    rel_s  = diff_s[24:0];
    if (rel_s >= BA3_START) begin
      bank_s = 2'd3; start_s = BA3_START;
    end else if (rel_s >= BA2_START) begin
      bank_s = 2'd2; start_s = BA2_START;
    end else if (rel_s >= BA1_START) begin
      bank_s = 2'd1; start_s = BA1_START;
    end else begin
      bank_s = 2'd0; start_s = 25'd0;
    end
    waddr_s = SDRAMW'((rel_s - start_s) >> 1'b1);
  end

  assign accept_s    = downloading & ioctl_wr & ~diff_s[25];
  assign push_data_s = {bank_s, waddr_s, ioctl_data, rel_s[0]};
  assign {head_ba_s, head_addr_s, head_byte_s, head_odd_s} = head_s;

  jtframe_prog_fifo #(.W(EW), .DEPTH(PROG_FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept_s),
    .din   (push_data_s),
    .pop   (pop_s),
    .dout  (head_s),
    .empty (empty_s),
    .full  (full_s)
  );

  // Write FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= PROG_IDLE;
    else     state_r <= state_nx;
  end

  // Next state; a pop only happens from IDLE so prog_rdy there is ignored
  always_comb begin
    state_nx = state_r;
    pop_s    = 1'b0;
    case (state_r)
      PROG_IDLE: begin
        if (!empty_s) begin
          pop_s    = 1'b1;
          state_nx = PROG_WRITE;
        end else begin
          state_nx = PROG_IDLE;
        end
      end
      PROG_WRITE: begin
        if (prog_rdy) state_nx = PROG_IDLE;
        else          state_nx = PROG_WRITE;
      end
      default: state_nx = PROG_IDLE;
    endcase
  end

  // Write request registers; fields stay frozen until the next pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= {SDRAMW{1'b0}};
      data_r <= 16'h0000;
      mask_r <= 2'b11;
      ba_r   <= 2'b00;
      we_r   <= 1'b0;
    end else if (pop_s) begin
      addr_r <= head_addr_s;
      data_r <= {head_byte_s, head_byte_s};
      mask_r <= head_odd_s ? 2'b01 : 2'b10;
      ba_r   <= head_ba_s;
      we_r   <= 1'b1;
    end else if ((state_r == PROG_WRITE) && prog_rdy) begin
      we_r   <= 1'b0;
    end
  end

  // Busy and sticky byte-loss flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      busy_r <= downloading | ~empty_s | (state_r == PROG_WRITE);
      ovf_r  <= ovf_r | (accept_s & full_s & ~pop_s);
    end
  end

  assign prog_addr  = addr_r;
  assign prog_data  = data_r;
  assign prog_mask  = mask_r;
  assign prog_ba    = ba_r;
  assign prog_we    = we_r;
  assign dwnld_busy = busy_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_jtframe_prog_pack.sv
// Scoreboard bench: two packers (HEADER 0 and 16) share one byte stream; a
// transaction-level model predicts accepted writes and drops.
module tb_jtframe_prog_pack;

  typedef struct packed {
    logic [1:0]  ba;
    logic [22:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_data = 8'd0;
  logic [1:0]  rdy_mode = 2'd0;   // 0 random, 1 fixed 2-cycle, 2 hold
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Address rules written directly from the mapping description
  function automatic exp_t model(input logic [24:0] a, input int hdr, input logic [7:0] d);
    int unsigned r, s;
    exp_t e;
    r = 32'(a) - 32'(hdr);
    if (r >= 32'h1C_0000)      begin e.ba = 2'd3; s = 32'h1C_0000; end
    else if (r >= 32'h18_0000) begin e.ba = 2'd2; s = 32'h18_0000; end
    else if (r >= 32'h10_0000) begin e.ba = 2'd1; s = 32'h10_0000; end
    else                       begin e.ba = 2'd0; s = 32'd0; end
    e.addr = 23'((r - s) / 32'd2);
    e.data = {d, d};
    e.mask = (r % 32'd2 == 32'd1) ? 2'b01 : 2'b10;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_sb
    localparam int HDR = (g == 0) ? 0 : 16;
    logic [22:0] paddr;
    logic [15:0] pdata;
    logic [1:0]  pmask, pba;
    logic        pwe, prdy, busy, ovf;
    logic        ovf_exp;
    int          wr_cnt, qsize;
    exp_t        q[$];
    int          dq[$];

    jtframe_prog_pack #(.HEADER(HDR)) u_dut (
      .clk(clk), .rst(rst), .downloading(downloading),
      .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
      .prog_addr(paddr), .prog_data(pdata), .prog_mask(pmask), .prog_ba(pba),
      .prog_we(pwe), .prog_rdy(prdy), .dwnld_busy(busy), .overflow(ovf)
    );

    // SDRAM responder: acknowledges after a chosen delay, sometimes pulses while idle
    initial begin
      int cnt, dly;
      cnt = 0; dly = 0; prdy = 1'b0;
      forever begin
        @(posedge clk); #1;
        prdy = 1'b0;
        if (rst || !pwe) begin
          cnt  = 0;
          prdy = !rst && (rdy_mode == 2'd0) && ($urandom_range(7) == 0);
        end else begin
          if (cnt == 0) dly = (rdy_mode == 2'd1) ? 2 : int'($urandom_range(3));
          if (rdy_mode != 2'd2 && cnt >= dly) begin
            prdy = 1'b1;
            dq.push_back(cnt + 1);
          end else begin
            cnt++;
          end
        end
      end
    end

    // Monitor and model: capacity of one write in flight plus four queued bytes
    initial begin
      logic prev, stable;
      int   dur, acc, done, edur;
      exp_t e, cap, cur;
      prev = 1'b0; stable = 1'b1; dur = 0; acc = 0; done = 0;
      ovf_exp = 1'b0; wr_cnt = 0; qsize = 0;
      forever begin
        @(negedge clk);
        cur = '{ba: pba, addr: paddr, data: pdata, mask: pmask};
        if (rst) begin
          q.delete(); dq.delete();
          prev = 1'b0; acc = 0; done = 0; ovf_exp = 1'b0; qsize = 0;
        end else begin
          if (!pwe && prev) begin
            done++;
            edur = (dq.size() > 0) ? dq.pop_front() : -1;
            check($sformatf("we_len%0d", g), dur, edur);
            check($sformatf("stable%0d", g), {31'd0, stable}, 32'd1);
          end
          if (pwe && !prev) begin
            wr_cnt++;
            if (q.size() == 0) begin
              check($sformatf("unexpected_write%0d", g), {31'd0, pwe}, 32'd0);
            end else begin
              e = q.pop_front();
              check($sformatf("ba%0d", g), pba, e.ba);
              check($sformatf("addr%0d", g), paddr, e.addr);
              check($sformatf("data%0d", g), pdata, e.data);
              check($sformatf("mask%0d", g), pmask, e.mask);
            end
            cap = cur; dur = 1; stable = 1'b1;
          end else if (pwe && prev) begin
            dur++;
            if (cur != cap) stable = 1'b0;
          end
          if (downloading && ioctl_wr && $signed(32'(ioctl_addr)) >= HDR) begin
            if (acc - done >= 5) ovf_exp = 1'b1;
            else begin
              q.push_back(model(ioctl_addr, HDR, ioctl_data));
              acc++;
            end
          end
          qsize = q.size();
          prev  = pwe;
        end
      end
    end
  end

  task automatic strobe(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((g_sb[0].qsize != 0 || g_sb[1].qsize != 0 || g_sb[0].pwe || g_sb[1].pwe) && n < 500) begin
      @(negedge clk); n++;
    end
    check("drain_done", {31'd0, (n < 500)}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_we0();
    int n = 0;
    @(negedge clk);
    while (!g_sb[0].pwe && n < 50) begin @(negedge clk); n++; end
    check("we0_seen", {31'd0, g_sb[0].pwe}, 32'd1);
  endtask

  task automatic chk_idle(input string t, input logic we, input logic [22:0] a, input logic [15:0] d,
                          input logic [1:0] m, input logic [1:0] b, input logic bsy, input logic o);
    check({t, "_we"}, {31'd0, we}, 32'd0);
    check({t, "_addr"}, a, 32'd0);
    check({t, "_data"}, d, 32'd0);
    check({t, "_mask"}, m, 32'd3);
    check({t, "_ba"}, b, 32'd0);
    check({t, "_busy"}, {31'd0, bsy}, 32'd0);
    check({t, "_ovf"}, {31'd0, o}, 32'd0);
  endtask

  function automatic logic [24:0] rand_addr();
    int unsigned b;
    case ($urandom_range(3))
      0: return 25'($urandom_range(63));
      1: begin
        case ($urandom_range(2))
          0: b = 32'h10_0000;
          1: b = 32'h18_0000;
          default: b = 32'h1C_0000;
        endcase
        return 25'(b + $urandom_range(40) - 32'd20);
      end
      default: return 25'($urandom);
    endcase
  endfunction

  initial begin
    int w0, w1, n;
    repeat (2) @(negedge clk);
    chk_idle("rst0", g_sb[0].pwe, g_sb[0].paddr, g_sb[0].pdata, g_sb[0].pmask, g_sb[0].pba, g_sb[0].busy, g_sb[0].ovf);
    chk_idle("rst1", g_sb[1].pwe, g_sb[1].paddr, g_sb[1].pdata, g_sb[1].pmask, g_sb[1].pba, g_sb[1].busy, g_sb[1].ovf);
    @(posedge clk); #1;
    rst = 1'b0; downloading = 1'b1;

    // Single odd byte: two-cycle latency, acknowledged two cycles after the request
    rdy_mode = 2'd1;
    strobe(25'd3, 8'hA5);
    @(negedge clk); check("lat_n1", {31'd0, g_sb[0].pwe}, 32'd0);
    @(negedge clk); check("lat_n2", {31'd0, g_sb[0].pwe}, 32'd1);
    check("a5_ba", g_sb[0].pba, 32'd0);
    check("a5_addr", g_sb[0].paddr, 32'd1);
    check("a5_data", g_sb[0].pdata, 32'hA5A5);
    check("a5_mask", g_sb[0].pmask, 32'd1);
    n = 0;
    while (g_sb[0].pwe && n < 20) begin n++; @(negedge clk); end
    check("a5_we_cycles", n, 32'd3);
    drain();

    // Bank boundaries
    rdy_mode = 2'd0;
    strobe(25'h10_0004, 8'h3C); wait_we0();
    check("b1_ba", g_sb[0].pba, 32'd1);
    check("b1_addr", g_sb[0].paddr, 32'd2);
    check("b1_mask", g_sb[0].pmask, 32'd2);
    drain();
    strobe(25'h1C_0001, 8'hC3); wait_we0();
    check("b3_ba", g_sb[0].pba, 32'd3);
    check("b3_addr", g_sb[0].paddr, 32'd0);
    drain();

    // Header skipping, strobes spaced so nothing backs up
    w0 = g_sb[0].wr_cnt; w1 = g_sb[1].wr_cnt;
    for (int a = 0; a < 18; a++) begin
      strobe(25'(a), 8'(a + 64));
      repeat (6) @(posedge clk);
      #1;
    end
    drain();
    check("hdr_writes", g_sb[1].wr_cnt - w1, 32'd2);
    check("nohdr_writes", g_sb[0].wr_cnt - w0, 32'd18);
    check("ovf_pre", {31'd0, g_sb[0].ovf}, 32'd0);

    // Fill: one in flight plus four queued, sixth byte lost
    rdy_mode = 2'd2;
    w0 = g_sb[0].wr_cnt;
    for (int i = 0; i < 5; i++) strobe(25'(32'h200 + i), 8'(i * 37 + 1));
    check("full_ovf0", {31'd0, g_sb[0].ovf}, 32'd0);
    check("full_ovf1", {31'd0, g_sb[1].ovf}, 32'd0);
    strobe(25'h205, 8'hFF);
    check("drop_ovf0", {31'd0, g_sb[0].ovf}, 32'd1);
    check("drop_ovf1", {31'd0, g_sb[1].ovf}, 32'd1);
    rdy_mode = 2'd0;
    drain();
    check("full_writes", g_sb[0].wr_cnt - w0, 32'd5);

    // Reset in the middle of a write with two bytes still queued
    rdy_mode = 2'd2;
    for (int i = 0; i < 3; i++) strobe(25'(32'h300 + i), 8'(i + 16));
    check("pre_rst_we", {31'd0, g_sb[0].pwe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_idle("mid0", g_sb[0].pwe, g_sb[0].paddr, g_sb[0].pdata, g_sb[0].pmask, g_sb[0].pba, g_sb[0].busy, g_sb[0].ovf);
    chk_idle("mid1", g_sb[1].pwe, g_sb[1].paddr, g_sb[1].pdata, g_sb[1].pmask, g_sb[1].pba, g_sb[1].busy, g_sb[1].ovf);
    @(posedge clk); #1;
    rst = 1'b0; rdy_mode = 2'd0;
    w0 = g_sb[0].wr_cnt; w1 = g_sb[1].wr_cnt;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, g_sb[0].busy}, 32'd1);
    repeat (20) @(negedge clk);
    check("post_rst_w0", g_sb[0].wr_cnt - w0, 32'd0);
    check("post_rst_w1", g_sb[1].wr_cnt - w1, 32'd0);
    @(posedge clk); #1;
    downloading = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {31'd0, g_sb[0].busy}, 32'd0);

    // Random traffic with random acknowledge timing
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      downloading = ($urandom_range(15) != 0);
      ioctl_wr    = ($urandom_range(2) == 0);
      ioctl_addr  = rand_addr();
      ioctl_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    ioctl_wr = 1'b0; downloading = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    check("rnd_ovf0", {31'd0, g_sb[0].ovf}, {31'd0, g_sb[0].ovf_exp});
    check("rnd_ovf1", {31'd0, g_sb[1].ovf}, {31'd0, g_sb[1].ovf_exp});
    check("rnd_busy0", {31'd0, g_sb[0].busy}, 32'd0);
    check("rnd_busy1", {31'd0, g_sb[1].busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
